// File: rtl/router_read_arbiter_if.sv
// Signal bundle between the arbiter, the three router output FIFOs and the
// merged downstream byte stream. The master side is the arbiter.
interface router_read_arbiter_if;
    logic       vld_out_0;
    logic       vld_out_1;
    logic       vld_out_2;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic [7:0] data_out_2;
    logic       read_enb_0;
    logic       read_enb_1;
    logic       read_enb_2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_abort;
    logic [1:0] grant;

    modport master (
        input  vld_out_0, vld_out_1, vld_out_2,
        input  data_out_0, data_out_1, data_out_2,
        input  out_ready,
        output read_enb_0, read_enb_1, read_enb_2,
        output out_valid, out_data, out_sop, out_eop, out_abort, grant
    );

    modport slave (
        output vld_out_0, vld_out_1, vld_out_2,
        output data_out_0, data_out_1, data_out_2,
        output out_ready,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  out_valid, out_data, out_sop, out_eop, out_abort, grant
    );
endinterface

// File: rtl/router_read_arbiter.sv
// Round-robin read scheduler: drains one whole packet at a time from the three
// router output FIFOs onto a single valid/ready byte stream with sop/eop/abort.
module router_read_arbiter #(
    parameter int NPORT   = 3,
    parameter int LEN_MSB = 7
) (
    input  logic                         clk,
    input  logic                         resetn,
    router_read_arbiter_if.master        bus
);

    localparam logic [1:0] LAST_PORT = 2'(NPORT - 1);
    localparam logic [1:0] NO_GRANT  = 2'b11;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [6:0] bytes_left_q, bytes_left_d;
    logic       pend_q, pend_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_sop_q, out_sop_d;
    logic       out_eop_q, out_eop_d;
    logic       out_abort_q, out_abort_d;

    logic [2:0] vld_vec;
    logic       vld_grant;
    logic [7:0] data_grant;
    logic       pop;
    logic       out_space;
    logic       active;
    logic       issue;
    logic       abort_fire;
    logic [1:0] cand0, cand1, cand2;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p >= LAST_PORT) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        vld_vec    = {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
        vld_grant  = 1'b0;
        data_grant = 8'h00;
        case (grant_q)
            2'd0: begin vld_grant = bus.vld_out_0; data_grant = bus.data_out_0; end
            2'd1: begin vld_grant = bus.vld_out_1; data_grant = bus.data_out_1; end
            2'd2: begin vld_grant = bus.vld_out_2; data_grant = bus.data_out_2; end
            default: ;
        endcase
    end

    // A read may only be issued when the output register is guaranteed free by
    // the time its data lands, which keeps the stream from ever overflowing.
    always_comb begin
        pop        = out_valid_q & bus.out_ready;
        out_space  = !out_valid_q || bus.out_ready;
        active     = ((state_q == HDR) || (state_q == BODY)) &&
                     (bytes_left_q != 7'd0) && !pend_q;
        issue      = resetn && active && vld_grant && out_space;
        abort_fire = active && !vld_grant && out_space;
        bus.read_enb_0 = issue && (grant_q == 2'd0);
        bus.read_enb_1 = issue && (grant_q == 2'd1);
        bus.read_enb_2 = issue && (grant_q == 2'd2);
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        bytes_left_d = bytes_left_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_abort_d  = out_abort_q;
        pend_d       = issue;
        cand0        = rr_ptr_q;
        cand1        = next_port(cand0);
        cand2        = next_port(cand1);

        if (pop) begin
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_abort_d = 1'b0;
        end
        if (issue) begin
            bytes_left_d = bytes_left_q - 7'd1;
        end

        case (state_q)
            IDLE: begin
                if (vld_vec[cand0]) begin
                    grant_d = cand0; state_d = HDR; bytes_left_d = 7'd1;
                end else if (vld_vec[cand1]) begin
                    grant_d = cand1; state_d = HDR; bytes_left_d = 7'd1;
                end else if (vld_vec[cand2]) begin
                    grant_d = cand2; state_d = HDR; bytes_left_d = 7'd1;
                end
            end
            HDR: begin
                if (pend_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = data_grant;
                    out_sop_d    = 1'b1;
                    out_eop_d    = 1'b0;
                    out_abort_d  = 1'b0;
                    bytes_left_d = 7'(data_grant[LEN_MSB:2]) + 7'd1;
                    state_d      = BODY;
                end
            end
            BODY: begin
                if (pend_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_grant;
                    out_sop_d   = 1'b0;
                    out_eop_d   = (bytes_left_q == 7'd0);
                    out_abort_d = 1'b0;
                    if (bytes_left_q == 7'd0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop) begin
                    rr_ptr_d = next_port(grant_q);
                    grant_d  = NO_GRANT;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // FIFO was flushed under us: close the packet with a marked filler byte.
        if (abort_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = 8'h00;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b1;
            out_abort_d = 1'b1;
            state_d     = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= NO_GRANT;
            rr_ptr_q     <= 2'd0;
            bytes_left_q <= 7'd0;
            pend_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_abort_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            bytes_left_q <= bytes_left_d;
            pend_q       <= pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_abort_q  <= out_abort_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_abort = out_abort_q;
    assign bus.grant     = grant_q;

endmodule

// File: tb/tb_router_read_arbiter.sv
// Directed bench for router_read_arbiter: three FIFO models feed the arbiter,
// a negedge monitor logs accepted bytes and read strobes for the test tasks.
module tb_router_read_arbiter;

    logic clk;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    router_read_arbiter_if bus();

    router_read_arbiter #(.NPORT(3), .LEN_MSB(7)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // FIFO models: registered read data, non-empty flag from the pointers.
    logic [7:0] fmem [3][64];
    int         wr_p [3] = '{0, 0, 0};
    int         rd_p [3] = '{0, 0, 0};
    logic [7:0] dout [3] = '{8'h00, 8'h00, 8'h00};
    logic [2:0] ren;

    assign ren            = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign bus.vld_out_0  = (wr_p[0] != rd_p[0]);
    assign bus.vld_out_1  = (wr_p[1] != rd_p[1]);
    assign bus.vld_out_2  = (wr_p[2] != rd_p[2]);
    assign bus.data_out_0 = dout[0];
    assign bus.data_out_1 = dout[1];
    assign bus.data_out_2 = dout[2];

    always @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (ren[p]) begin
                dout[p] <= fmem[p][rd_p[p] % 64];
                rd_p[p] <= rd_p[p] + 1;
            end
        end
    end

    logic [7:0] acc_data  [$];
    logic       acc_sop   [$];
    logic       acc_eop   [$];
    logic       acc_abort [$];
    logic [1:0] acc_grant [$];
    int         rd_port   [$];
    int         rd_cyc    [$];
    int         overlap_err = 0;
    int         stray_err   = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.out_valid && bus.out_ready) begin
                acc_data.push_back(bus.out_data);
                acc_sop.push_back(bus.out_sop);
                acc_eop.push_back(bus.out_eop);
                acc_abort.push_back(bus.out_abort);
                acc_grant.push_back(bus.grant);
            end
            if ((32'(ren[0]) + 32'(ren[1]) + 32'(ren[2])) > 1) overlap_err++;
            for (int p = 0; p < 3; p++) begin
                if (ren[p]) begin
                    rd_port.push_back(p);
                    rd_cyc.push_back(cycle);
                    if (bus.grant != 2'(p)) stray_err++;
                end
            end
        end
    end

    task automatic push(input int p, input logic [7:0] b);
        fmem[p][wr_p[p] % 64] = b;
        wr_p[p]++;
    endtask

    task automatic wait_acc(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk); #1;
            if (acc_data.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int reads_on(input int p, input int from);
        int cnt = 0;
        for (int i = from; i < rd_port.size(); i++) if (rd_port[i] == p) cnt++;
        return cnt;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_data got=%h exp=00", bus.out_data); end
        checks++; if ({bus.out_sop, bus.out_eop, bus.out_abort} !== 3'b000) begin failures++; $display("[TB] FAIL rst_flags got=%b exp=000", {bus.out_sop, bus.out_eop, bus.out_abort}); end
        checks++; if (bus.grant !== 2'b11) begin failures++; $display("[TB] FAIL rst_grant got=%b exp=11", bus.grant); end
        checks++; if (ren !== 3'b000) begin failures++; $display("[TB] FAIL rst_read_enb got=%b exp=000", ren); end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.grant !== 2'b11) begin failures++; $display("[TB] FAIL idle_grant got=%b exp=11", bus.grant); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_single();
        logic [7:0] exp_d [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        int base = acc_data.size();
        int rbase = rd_port.size();
        bit ok;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) push(1, exp_d[i]);
        wait_acc(base + 5, ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL single_timeout got=%0d bytes exp=5", acc_data.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (acc_data[base+i] !== exp_d[i] || acc_sop[base+i] !== (i == 0) ||
                    acc_eop[base+i] !== (i == 4) || acc_grant[base+i] !== 2'd1) begin
                    failures++;
                    $display("[TB] FAIL single_byte%0d got=%h sop=%b eop=%b grant=%0d exp=%h sop=%b eop=%b grant=1",
                             i, acc_data[base+i], acc_sop[base+i], acc_eop[base+i], acc_grant[base+i],
                             exp_d[i], (i == 0), (i == 4));
                end
            end
        end
        repeat (2) @(negedge clk); #1;
        checks++; if (bus.grant !== 2'b11) begin failures++; $display("[TB] FAIL single_release got=%b exp=11", bus.grant); end
        checks++; if (rd_port.size() - rbase !== 5) begin failures++; $display("[TB] FAIL single_reads got=%0d exp=5", rd_port.size() - rbase); end
        if (rd_port.size() - rbase >= 5) begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (rd_cyc[rbase+i] - rd_cyc[rbase+i-1] !== 2 || rd_port[rbase+i] !== 1) begin
                    failures++;
                    $display("[TB] FAIL single_spacing%0d got=%0d port=%0d exp=2 port=1",
                             i, rd_cyc[rbase+i] - rd_cyc[rbase+i-1], rd_port[rbase+i]);
                end
            end
        end
    endtask

    task automatic test_len0();
        int base = acc_data.size();
        int rbase = rd_port.size();
        bit ok;
        @(posedge clk); #1;
        push(2, 8'h00);
        push(2, 8'h77);
        wait_acc(base + 2, ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL len0_timeout got=%0d bytes exp=2", acc_data.size() - base);
        end else begin
            checks++;
            if (acc_data[base] !== 8'h00 || acc_sop[base] !== 1'b1 || acc_eop[base] !== 1'b0) begin
                failures++; $display("[TB] FAIL len0_hdr got=%h sop=%b eop=%b exp=00 sop=1 eop=0", acc_data[base], acc_sop[base], acc_eop[base]);
            end
            checks++;
            if (acc_data[base+1] !== 8'h77 || acc_sop[base+1] !== 1'b0 || acc_eop[base+1] !== 1'b1 || acc_grant[base+1] !== 2'd2) begin
                failures++; $display("[TB] FAIL len0_par got=%h sop=%b eop=%b grant=%0d exp=77 sop=0 eop=1 grant=2", acc_data[base+1], acc_sop[base+1], acc_eop[base+1], acc_grant[base+1]);
            end
        end
        repeat (4) @(negedge clk); #1;
        checks++; if (reads_on(2, rbase) !== 2) begin failures++; $display("[TB] FAIL len0_reads got=%0d exp=2", reads_on(2, rbase)); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp1_d [6] = '{8'h00, 8'hA0, 8'h00, 8'hB0, 8'h00, 8'hC0};
        logic [1:0] exp1_g [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        logic [7:0] exp2_d [6] = '{8'h00, 8'hC2, 8'h00, 8'hA2, 8'h00, 8'hB2};
        logic [1:0] exp2_g [6] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
        int base = acc_data.size();
        bit ok;
        @(posedge clk); #1;
        push(0, 8'h00); push(0, 8'hA0);
        push(1, 8'h00); push(1, 8'hB0);
        push(2, 8'h00); push(2, 8'hC0);
        wait_acc(base + 6, ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL rr1_timeout got=%0d bytes exp=6", acc_data.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_data[base+i] !== exp1_d[i] || acc_grant[base+i] !== exp1_g[i]) begin
                    failures++; $display("[TB] FAIL rr1_byte%0d got=%h grant=%0d exp=%h grant=%0d", i, acc_data[base+i], acc_grant[base+i], exp1_d[i], exp1_g[i]);
                end
            end
        end
        repeat (3) @(posedge clk); #1;
        base = acc_data.size();
        push(1, 8'h00); push(1, 8'hB1);
        wait_acc(base + 2, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rr_mid_timeout got=%0d bytes exp=2", acc_data.size() - base); end
        repeat (3) @(posedge clk); #1;
        base = acc_data.size();
        push(0, 8'h00); push(0, 8'hA2);
        push(1, 8'h00); push(1, 8'hB2);
        push(2, 8'h00); push(2, 8'hC2);
        wait_acc(base + 6, ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL rr2_timeout got=%0d bytes exp=6", acc_data.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_data[base+i] !== exp2_d[i] || acc_grant[base+i] !== exp2_g[i]) begin
                    failures++; $display("[TB] FAIL rr2_byte%0d got=%h grant=%0d exp=%h grant=%0d", i, acc_data[base+i], acc_grant[base+i], exp2_d[i], exp2_g[i]);
                end
            end
        end
        checks++; if (overlap_err !== 0) begin failures++; $display("[TB] FAIL rr_overlap got=%0d exp=0", overlap_err); end
        checks++; if (stray_err !== 0) begin failures++; $display("[TB] FAIL rr_stray_read got=%0d exp=0", stray_err); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [6] = '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        int base = acc_data.size();
        int rhold;
        bit ok;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) push(0, exp_d[i]);
        wait_acc(base + 2, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_start_timeout got=%0d bytes exp=2", acc_data.size() - base); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk); #1;
        rhold = rd_port.size();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h02) begin
                failures++; $display("[TB] FAIL bp_hold%0d got=%h valid=%b exp=02 valid=1", i, bus.out_data, bus.out_valid);
            end
        end
        checks++; if (rd_port.size() !== rhold) begin failures++; $display("[TB] FAIL bp_no_read got=%0d exp=0", rd_port.size() - rhold); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_acc(base + 6, ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL bp_timeout got=%0d bytes exp=6", acc_data.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (acc_data[base+i] !== exp_d[i] || acc_eop[base+i] !== (i == 5)) begin
                    failures++; $display("[TB] FAIL bp_byte%0d got=%h eop=%b exp=%h eop=%b", i, acc_data[base+i], acc_eop[base+i], exp_d[i], (i == 5));
                end
            end
        end
        repeat (3) @(negedge clk); #1;
        checks++; if (acc_data.size() !== base + 6) begin failures++; $display("[TB] FAIL bp_extra got=%0d bytes exp=6", acc_data.size() - base); end
    endtask

    task automatic test_abort();
        int base = acc_data.size();
        int rbase = rd_port.size();
        bit ok = 1'b0;
        @(posedge clk); #1;
        push(0, 8'h10);
        for (int i = 1; i < 6; i++) push(0, 8'hA0 + 8'(i));
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (reads_on(0, rbase) >= 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("[TB] FAIL abort_reads_timeout got=%0d exp=2", reads_on(0, rbase)); end
        @(posedge clk); #1;
        wr_p[0] = rd_p[0];
        wait_acc(base + 3, ok);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL abort_timeout got=%0d bytes exp=3", acc_data.size() - base);
        end else begin
            checks++;
            if (acc_data[base] !== 8'h10 || acc_sop[base] !== 1'b1 || acc_data[base+1] !== 8'hA1) begin
                failures++; $display("[TB] FAIL abort_prefix got=%h,%h sop=%b exp=10,a1 sop=1", acc_data[base], acc_data[base+1], acc_sop[base]);
            end
            checks++;
            if (acc_data[base+2] !== 8'h00 || acc_eop[base+2] !== 1'b1 || acc_abort[base+2] !== 1'b1 || acc_grant[base+2] !== 2'd0) begin
                failures++; $display("[TB] FAIL abort_byte got=%h eop=%b abort=%b grant=%0d exp=00 eop=1 abort=1 grant=0", acc_data[base+2], acc_eop[base+2], acc_abort[base+2], acc_grant[base+2]);
            end
        end
        repeat (20) @(negedge clk); #1;
        checks++; if (reads_on(0, rbase) !== 2) begin failures++; $display("[TB] FAIL abort_reads got=%0d exp=2", reads_on(0, rbase)); end
        checks++; if (bus.grant !== 2'b11) begin failures++; $display("[TB] FAIL abort_idle got=%b exp=11", bus.grant); end
        checks++; if (acc_data.size() !== base + 3) begin failures++; $display("[TB] FAIL abort_extra got=%0d bytes exp=3", acc_data.size() - base); end
    endtask

    task automatic test_reset_mid();
        int base = acc_data.size();
        bit ok;
        @(posedge clk); #1;
        push(0, 8'h10);
        for (int i = 1; i < 6; i++) push(0, 8'hB0 + 8'(i));
        wait_acc(base + 2, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL rstmid_timeout got=%0d bytes exp=2", acc_data.size() - base); end
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_out got=%h valid=%b exp=00 valid=0", bus.out_data, bus.out_valid); end
        checks++; if ({bus.out_sop, bus.out_eop, bus.out_abort} !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_flags got=%b exp=000", {bus.out_sop, bus.out_eop, bus.out_abort}); end
        checks++; if (bus.grant !== 2'b11 || ren !== 3'b000) begin failures++; $display("[TB] FAIL rstmid_grant got=%b ren=%b exp=11 ren=000", bus.grant, ren); end
        @(negedge clk); #1;
        checks++; if (bus.grant !== 2'd0) begin failures++; $display("[TB] FAIL rstmid_rearb got=%b exp=00", bus.grant); end
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        for (int p = 0; p < 3; p++) wr_p[p] = rd_p[p];
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_len0();
        test_round_robin();
        test_backpressure();
        test_abort();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
